// File: rtl/fir_pkg.sv
// Shared FIR register map, ap_ctrl bit positions and master state encoding.
// Used by both the AXI-lite master sequencer and the FIR slave.
package fir_pkg;

  localparam logic [11:0] ADDR_AP_CTRL  = 12'h000;
  localparam logic [11:0] ADDR_DATA_LEN = 12'h010;
  localparam logic [11:0] ADDR_TAP_BASE = 12'h020;

  localparam int AP_START_BIT = 0;
  localparam int AP_DONE_BIT  = 1;
  localparam int AP_IDLE_BIT  = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_LEN,
    S_WR_TAP,
    S_WR_START,
    S_POLL_AR,
    S_POLL_R,
    S_FINISH
  } state_e;

  function automatic logic [11:0] tap_addr(input logic [3:0] idx);
    return ADDR_TAP_BASE + {6'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/axil_wr_xact.sv
// Single AXI-lite write: AW and W raised together, each dropped after its
// own handshake; complete fires in the cycle the last handshake lands.
module axil_wr_xact #(
  parameter int AW = 12,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          go,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data,
  output logic          complete,
  output logic          awvalid,
  input  logic          awready,
  output logic [AW-1:0] awaddr,
  output logic          wvalid,
  input  logic          wready,
  output logic [DW-1:0] wdata
);

  logic          aw_q, w_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;
  logic          active;

  assign active   = aw_q | w_q;
  assign complete = active
                  & (~aw_q | awready)
                  & (~w_q  | wready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_q   <= 1'b0;
      w_q    <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else if (!active) begin
      if (go) begin
        aw_q   <= 1'b1;
        w_q    <= 1'b1;
        addr_q <= addr;
        data_q <= data;
      end
    end else begin
      if (aw_q && awready) aw_q <= 1'b0;
      if (w_q && wready)   w_q  <= 1'b0;
    end
  end

  assign awvalid = aw_q;
  assign wvalid  = w_q;
  assign awaddr  = addr_q;
  assign wdata   = data_q;

endmodule

// File: rtl/fir_axil_master.sv
// AXI-lite master that programs the FIR slave (length, taps, ap_start)
// and polls ap_ctrl until ap_done or the poll budget runs out.
module fir_axil_master
  import fir_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11,
  parameter int POLL_MAX    = 1024
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  output logic                   awvalid,
  input  logic                   awready,
  output logic [pADDR_WIDTH-1:0] awaddr,
  output logic                   wvalid,
  input  logic                   wready,
  output logic [pDATA_WIDTH-1:0] wdata,
  output logic                   arvalid,
  input  logic                   arready,
  output logic [pADDR_WIDTH-1:0] araddr,
  input  logic                   rvalid,
  output logic                   rready,
  input  logic [pDATA_WIDTH-1:0] rdata,
  input  logic                   tap_we,
  input  logic [3:0]             tap_idx,
  input  logic [pDATA_WIDTH-1:0] tap_wdata,
  input  logic                   cfg_start,
  input  logic [pDATA_WIDTH-1:0] cfg_len,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int         PW       = $clog2(POLL_MAX + 1);
  localparam logic [3:0] TAP_LAST = 4'(Tape_Num - 1);

  state_e                 state_q, state_d;
  logic [pDATA_WIDTH-1:0] len_q, len_d;
  logic [3:0]             tap_cnt_q, tap_cnt_d;
  logic [PW-1:0]          poll_q, poll_d;
  logic                   err_q, err_d;
  logic [pDATA_WIDTH-1:0] tap_q [Tape_Num];

  logic                   wr_go, wr_done;
  logic [pADDR_WIDTH-1:0] wr_addr;
  logic [pDATA_WIDTH-1:0] wr_data;
  logic                   unused_rd;

  assign unused_rd = ^{rdata[pDATA_WIDTH-1:AP_DONE_BIT+1],
                       rdata[AP_DONE_BIT-1:0]};

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      for (int i = 0; i < Tape_Num; i++) tap_q[i] <= '0;
    end else if (tap_we && state_q == S_IDLE
                 && int'(tap_idx) < Tape_Num) begin
      tap_q[tap_idx] <= tap_wdata;
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      tap_cnt_q <= '0;
      poll_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      tap_cnt_q <= tap_cnt_d;
      poll_q    <= poll_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    tap_cnt_d = tap_cnt_q;
    poll_d    = poll_q;
    err_d     = err_q;
    wr_go     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          state_d = S_WR_LEN;
          len_d   = cfg_len;
          err_d   = 1'b0;
        end
      end
      S_WR_LEN: begin
        wr_go   = 1'b1;
        wr_addr = pADDR_WIDTH'(ADDR_DATA_LEN);
        wr_data = len_q;
        if (wr_done) state_d = S_WR_TAP;
      end
      S_WR_TAP: begin
        wr_go   = 1'b1;
        wr_addr = pADDR_WIDTH'(tap_addr(tap_cnt_q));
        wr_data = tap_q[tap_cnt_q];
        if (wr_done) begin
          if (tap_cnt_q == TAP_LAST) begin
            tap_cnt_d = '0;
            state_d   = S_WR_START;
          end else begin
            tap_cnt_d = tap_cnt_q + 4'd1;
          end
        end
      end
      S_WR_START: begin
        wr_go   = 1'b1;
        wr_addr = pADDR_WIDTH'(ADDR_AP_CTRL);
        wr_data[AP_START_BIT] = 1'b1;
        if (wr_done) state_d = S_POLL_AR;
      end
      S_POLL_AR: begin
        if (arready) state_d = S_POLL_R;
      end
      S_POLL_R: begin
        if (rvalid) begin
          if (rdata[AP_DONE_BIT]) begin
            state_d = S_FINISH;
          end else if (int'(poll_q) + 1 >= POLL_MAX) begin
            err_d   = 1'b1;
            state_d = S_FINISH;
          end else begin
            poll_d  = poll_q + 1'b1;
            state_d = S_POLL_AR;
          end
        end
      end
      S_FINISH: begin
        poll_d  = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  axil_wr_xact #(
    .AW(pADDR_WIDTH),
    .DW(pDATA_WIDTH)
  ) u_wr (
    .clk     (axis_clk),
    .rst_n   (axis_rst_n),
    .go      (wr_go),
    .addr    (wr_addr),
    .data    (wr_data),
    .complete(wr_done),
    .awvalid (awvalid),
    .awready (awready),
    .awaddr  (awaddr),
    .wvalid  (wvalid),
    .wready  (wready),
    .wdata   (wdata)
  );

  assign arvalid = (state_q == S_POLL_AR);
  assign rready  = (state_q == S_POLL_R);
  assign araddr  = pADDR_WIDTH'(ADDR_AP_CTRL);
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_FINISH);
  assign err     = err_q;

endmodule

// File: doc/fir_axil_master.md
FIR_AXIL_MASTER -- requirements
Module: fir_axil_master

Interface
REQ-001 SHALL have parameters: pADDR_WIDTH, 12, AXI-lite address width; pDATA_WIDTH, 32, data width; Tape_Num, 11, tap count; POLL_MAX, 1024, maximum status reads before timeout.
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 SHALL have ports: axis_clk  in  1  clock; axis_rst_n  in  1  async active-low reset.
REQ-004 Port: awvalid  out  1  write-address valid; awready  in  1  write-address ready; awaddr  out  pADDR_WIDTH  write address.
REQ-005 Port: wvalid  out  1  write-data valid; wready  in  1  write-data ready; wdata  out  pDATA_WIDTH  write data.
REQ-006 Port: arvalid  out  1  read-address valid; arready  in  1; araddr  out  pADDR_WIDTH; rvalid  in  1; rready  out  1; rdata  in  pDATA_WIDTH.
REQ-007 Port: tap_we  in  1  load tap buffer; tap_idx  in  4  tap index; tap_wdata  in  pDATA_WIDTH  coefficient.
REQ-008 Port: cfg_start  in  1  start pulse; cfg_len  in  pDATA_WIDTH  data length; busy  out  1; done  out  1  one-cycle completion pulse; err  out  1  sticky timeout flag.

Function
REQ-009 SHALL hold a Tape_Num x pDATA_WIDTH tap buffer, written when tap_we=1, busy=0 and tap_idx<Tape_Num; other writes ignored.
REQ-010 Register map of the FIR slave: 0x00 ap_ctrl (bit0 ap_start, bit1 ap_done, bit2 ap_idle), 0x10 data_length, 0x20+4*i tap i.
REQ-011 States: IDLE, WR_LEN, WR_TAP, WR_START, POLL_AR, POLL_R, FINISH.
REQ-012 IDLE -> WR_LEN on cfg_start=1; cfg_len is latched that cycle; busy=1 in every non-IDLE state.
REQ-013 Write transaction: awvalid and wvalid asserted together the cycle after state entry; each is deasserted the cycle after its own handshake (valid&ready); transaction complete when both handshakes have occurred, in either order or the same cycle.
REQ-014 awaddr/wdata SHALL stay stable while the corresponding valid is high.
REQ-015 No write-response channel exists; completion of REQ-013 ends the write.
REQ-016 WR_LEN writes cfg_len to 0x10, then WR_TAP.
REQ-017 WR_TAP writes taps 0..Tape_Num-1 in ascending order to 0x20+4*i, one transaction each; after tap Tape_Num-1 -> WR_START.
REQ-018 WR_START writes 0x00000001 to 0x00, then POLL_AR.
REQ-019 POLL_AR asserts arvalid with araddr=0x00 until arready; -> POLL_R.
REQ-020 POLL_R holds rready=1; on rvalid: rdata[1]=1 -> FINISH; else poll count increments and -> POLL_AR, unless count reaches POLL_MAX, then err=1 and -> FINISH.
REQ-021 FINISH pulses done for exactly one cycle, clears the poll counter, and returns to IDLE.
REQ-022 cfg_start while busy=1 SHALL be ignored.
REQ-023 err SHALL clear on the next accepted cfg_start.
REQ-024 At most one outstanding transaction; read and write channels never active simultaneously.

Reset
REQ-025 On axis_rst_n=0: state IDLE; awvalid, wvalid, arvalid, rready, busy, done, err = 0; awaddr, araddr, wdata = 0; counters = 0; tap buffer = 0.
REQ-026 Reset mid-transaction SHALL drop all valids immediately (asynchronously) with no resume.

Structure
REQ-027 Register offsets, ap_ctrl bit positions and state encodings SHALL live in a shared package, fir_pkg, also used by the FIR slave.
REQ-028 A sub-module axil_wr_xact SHALL implement the single write handshake of REQ-013 (inputs: go, addr, data; output: complete).

Verification
REQ-029 Load taps {0,-10,-9,23,56,63,56,23,-9,-10,0}, cfg_len=600, slave always ready -> writes observed in order 0x10=600, 0x20..0x48 = taps, 0x00=1; then reads of 0x00.
REQ-030 Slave asserts awready 3 cycles before wready on every write -> awvalid drops after its handshake, wvalid held until its own; no duplicate or lost writes.
REQ-031 Slave returns rdata=0x4 twice then 0x6 -> exactly 3 reads, done pulses 1 cycle, err=0, busy falls with done.
REQ-032 POLL_MAX=4, slave always returns 0x0 -> 4 reads, err=1, done pulse, next cfg_start clears err.
REQ-033 cfg_start and tap_we asserted during WR_TAP -> both ignored; the write sequence and tap values written are unchanged.
REQ-034 Assert axis_rst_n=0 during a tap write with awvalid high -> all valids 0 immediately; after release state IDLE, busy=0.
